// File: rtl/keypad_pkg.sv
// Shared types and key-code constants for the keypad scan decoder.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  localparam logic [4:0] KEY_NONE = 5'b11111;
  localparam logic [4:0] KEY_A    = 5'd10;
  localparam logic [4:0] KEY_B    = 5'd11;
  localparam logic [4:0] KEY_C    = 5'd12;
  localparam logic [4:0] KEY_D    = 5'd13;
  localparam logic [4:0] KEY_STAR = 5'd14;
  localparam logic [4:0] KEY_HASH = 5'd15;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

  // Layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  function automatic logic [4:0] map(input logic [1:0] r, input logic [1:0] c);
    logic [4:0] code;
    if (c == 2'd3) begin
      code = KEY_A + 5'(r);
    end else if (r == 2'd3) begin
      unique case (c)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 5'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = 5'(3 * int'(r) + int'(c) + 1);
    end
    return code;
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] pat);
    logic [1:0] idx;
    idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (!pat[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Saturating stable-sample counter; shared by press and release debouncing.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic match,
  output logic done
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // clear restarts the run; the current sample still counts if it matches
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = match ? CNT_W'(1) : '0;
    end else if (!match) begin
      cnt_d = '0;
    end else if (cnt_q < CntMax) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CntMax);

endmodule

// File: rtl/keypad_scan_decoder.sv
// 4x4 keypad scanner with debounced single-cycle press strobe.
// Define KEYPAD_REPEAT_EN to re-pulse press every REPEAT_CYCLES while a key stays down.
module keypad_scan_decoder
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned REPEAT_CYCLES   = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [4:0] key_code,
  output logic       press,
  output logic       key_held
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);
  localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [3:0]       row_meta_q, row_s_q;
  state_t           state_q, state_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [3:0]       row_pat_q, row_pat_d;
  logic [4:0]       key_code_q, key_code_d;
  logic             press_q, press_d;
  logic             held_q, held_d;
  logic             db_clear, db_match, db_done;
  logic             sample;
`ifdef KEYPAD_REPEAT_EN
  logic [CNT_W-1:0] rep_q, rep_d;
`endif

  keypad_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .clock(clock),
    .reset(reset),
    .clear(db_clear),
    .match(db_match),
    .done (db_done)
  );

  assign sample = (div_q == DIV_W'(SCAN_DIV - 1));

  always_comb begin
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    div_d      = div_q;
    row_idx_d  = row_idx_q;
    row_pat_d  = row_pat_q;
    key_code_d = key_code_q;
    press_d    = 1'b0;
    held_d     = held_q;
    db_clear   = 1'b0;
    db_match   = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d      = rep_q;
`endif
    unique case (state_q)
      SCAN: begin
        db_clear = 1'b1;
        if (sample) begin
          div_d = '0;
          // two or more low rows are ambiguous and treated like no key
          if ($onehot(~row_s_q)) begin
            db_match  = 1'b1;
            state_d   = DEBOUNCE;
            row_pat_d = row_s_q;
            row_idx_d = low_index(row_s_q);
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      DEBOUNCE: begin
        db_match = (row_s_q == row_pat_q);
        if (db_done) begin
          state_d    = HELD;
          key_code_d = map(row_idx_q, col_idx_q);
          press_d    = 1'b1;
          held_d     = 1'b1;
          db_clear   = 1'b1;
          db_match   = 1'b0;
`ifdef KEYPAD_REPEAT_EN
          rep_d      = '0;
`endif
        end else if (!db_match) begin
          state_d   = SCAN;
          col_idx_d = col_idx_q + 2'd1;
          div_d     = '0;
        end
      end
      HELD: begin
        db_match = (row_s_q == 4'b1111);
        if (db_done) begin
          state_d   = SCAN;
          held_d    = 1'b0;
          col_idx_d = col_idx_q + 2'd1;
          div_d     = '0;
        end
`ifdef KEYPAD_REPEAT_EN
        else if (!row_s_q[row_idx_q]) begin
          if (rep_q == CNT_W'(REPEAT_CYCLES - 1)) begin
            press_d = 1'b1;
            rep_d   = '0;
          end else begin
            rep_d = rep_q + CNT_W'(1);
          end
        end else begin
          rep_d = '0;
        end
`endif
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_meta_q <= 4'b1111;
      row_s_q    <= 4'b1111;
      state_q    <= SCAN;
      col_idx_q  <= '0;
      div_q      <= '0;
      row_idx_q  <= '0;
      row_pat_q  <= 4'b1111;
      key_code_q <= KEY_NONE;
      press_q    <= 1'b0;
      held_q     <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q      <= '0;
`endif
    end else begin
      row_meta_q <= row;
      row_s_q    <= row_meta_q;
      state_q    <= state_d;
      col_idx_q  <= col_idx_d;
      div_q      <= div_d;
      row_idx_q  <= row_idx_d;
      row_pat_q  <= row_pat_d;
      key_code_q <= key_code_d;
      press_q    <= press_d;
      held_q     <= held_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q      <= rep_d;
`endif
    end
  end

  assign col      = ~(4'b0001 << col_idx_q);
  assign key_code = key_code_q;
  assign press    = press_q;
  assign key_held = held_q;

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Scoreboard bench for keypad_scan_decoder with a behavioural 4x4 key matrix.
module tb_keypad_scan_decoder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [4:0]  key_code;
  logic        press;
  logic        key_held;
  logic [15:0] keys = '0;  // keys[r*4+c] = key (r,c) down

  int          errors = 0;
  int          checks = 0;
  int          npress = 0;
  logic        press_prev = 1'b0;
  logic [4:0]  exp_q[$];

  always #5 clock = ~clock;

  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      if (|(keys[r*4 +: 4] & ~col)) row[r] = 1'b0;
    end
  end

  keypad_scan_decoder #(
    .SCAN_DIV       (4),
    .DEBOUNCE_CYCLES(8),
    .REPEAT_CYCLES  (16)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .row     (row),
    .col     (col),
    .key_code(key_code),
    .press   (press),
    .key_held(key_held)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (press) begin
      npress++;
      check("press_gap", 32'(press_prev), 32'd0);
      if (exp_q.size() == 0) check("sb_unexpected_press", 32'(exp_q.size()), 32'd1);
      else check("key_code", 32'(key_code), 32'(exp_q.pop_front()));
    end
    press_prev <= press;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_press(input string tag, input int base);
    for (int i = 0; i < 300 && npress <= base; i++) cyc(1);
    check(tag, 32'(npress > base), 32'd1);
  endtask

  task automatic wait_released(input string tag);
    for (int i = 0; i < 100 && key_held; i++) cyc(1);
    check(tag, 32'(key_held), 32'd0);
  endtask

  task automatic wait_col(input logic [3:0] val);
    for (int i = 0; i < 40 && col == val; i++) cyc(1);
    for (int i = 0; i < 40 && col != val; i++) cyc(1);
    check("wait_col", 32'(col), 32'(val));
  endtask

  task automatic press_key(input string tag, input int idx, input logic [4:0] code);
    int base;
    base = npress;
    exp_q.push_back(code);
    keys[idx] = 1'b1;
    wait_press({tag, "_press"}, base);
    cyc(10);
    keys[idx] = 1'b0;
    wait_released({tag, "_release"});
    check({tag, "_count"}, 32'(npress - base), 32'd1);
  endtask

  initial begin
    int base;
    int n;
    int changes;
    int reps;
    logic [3:0] prev;

`ifdef KEYPAD_REPEAT_EN
    reps = 3;
`else
    reps = 0;
`endif

    // async reset before any clock edge
    #1 reset = 1'b1;
    #2;
    check("rst_col", 32'(col), 32'h0e);
    check("rst_key_code", 32'(key_code), 32'h1f);
    check("rst_press", 32'(press), 32'd0);
    check("rst_key_held", 32'(key_held), 32'd0);
    cyc(3);
    reset = 1'b0;
    cyc(2);

    // '5' held 60 cycles after acceptance
    base = npress;
    exp_q.push_back(5'd5);
    for (int i = 0; i < reps; i++) exp_q.push_back(5'd5);
    keys[5] = 1'b1;
    wait_press("t2_press", base);
    cyc(60);
    check("t2_count", 32'(npress - base), 32'(1 + reps));
    check("t2_held", 32'(key_held), 32'd1);
    check("t2_code", 32'(key_code), 32'd5);
    keys[5] = 1'b0;
    n = 0;
    while (key_held && n < 40) begin
      cyc(1);
      n++;
    end
    check("t2_release_latency", 32'(n), 32'd11);

    // bounce on '5': 3 low cycles only
    wait_col(4'b1101);
    base = npress;
    keys[5] = 1'b1;
    cyc(3);
    keys[5] = 1'b0;
    for (int i = 0; i < 20 && col == 4'b1101; i++) cyc(1);
    check("t3_next_col", 32'(col), 32'h0b);
    cyc(20);
    check("t3_no_press", 32'(npress - base), 32'd0);

    // '#' then '9'
    press_key("t4_hash", 14, 5'd15);
    press_key("t4_nine", 10, 5'd9);

    // reset while '3' is held
    base = npress;
    exp_q.push_back(5'd3);
    keys[2] = 1'b1;
    wait_press("t1_press", base);
    cyc(2);
    #1 reset = 1'b1;
    #1;
    check("t1_col", 32'(col), 32'h0e);
    check("t1_key_code", 32'(key_code), 32'h1f);
    check("t1_press", 32'(press), 32'd0);
    check("t1_key_held", 32'(key_held), 32'd0);
    keys[2] = 1'b0;
    cyc(1);
    reset = 1'b0;
    cyc(2);

    // '1' and '4' together are ambiguous
    base = npress;
    keys[0] = 1'b1;
    keys[4] = 1'b1;
    cyc(4);
    prev = col;
    changes = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (col != prev) changes++;
      prev = col;
    end
    check("t5_rotations", 32'(changes), 32'd10);
    check("t5_no_press", 32'(npress - base), 32'd0);
    keys = '0;

    // reset during debounce of '7'
    wait_col(4'b1110);
    base = npress;
    keys[8] = 1'b1;
    cyc(6);
    check("t5_col_frozen", 32'(col), 32'h0e);
    #1 reset = 1'b1;
    keys[8] = 1'b0;
    cyc(1);
    reset = 1'b0;
    cyc(30);
    check("t5_reset_no_press", 32'(npress - base), 32'd0);
    check("t5_reset_code", 32'(key_code), 32'h1f);

    // '0' held long enough for three repeat intervals
    base = npress;
    exp_q.push_back(5'd0);
    for (int i = 0; i < reps; i++) exp_q.push_back(5'd0);
    keys[13] = 1'b1;
    wait_press("t6_press", base);
    cyc(52);
    keys[13] = 1'b0;
    wait_released("t6_release");
    check("t6_count", 32'(npress - base), 32'(1 + reps));
    check("t6_code", 32'(key_code), 32'd0);

    cyc(5);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
